varint_field_seq: RTL and testbench
===================================

Name: varint_field_seq

Overview:
Sequencer that feeds the varint serializer unit: accepts protobuf field descriptors through a small FIFO, then issues each field to the serializer as a tag varint followed by a value varint. Tracks the destination write pointer from the serializer's reported byte count and pulses a message-complete flag when the queue has drained after `fin`. Sits between the message walker and the single shared varint serializer instance.

Parameters:
FIFO_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
TIMEOUT, 64, max cycles a serializer op may run before error
TAG_FTYPE, 5'd4, field_type driven while serializing a tag (plain varint, no zigzag)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin message; latches base_addr; ignored while busy
base_addr  in  64  first destination byte address
fld_valid  in  1  descriptor valid
fld_ready  out  1  FIFO can accept (= !full)
fld_num  in  29  protobuf field number
fld_type  in  5  field_type passed to serializer for the value
fld_value  in  64  field value
fin  in  1  no more fields for this message (level or pulse; latched)
vu_en  out  1  serializer enable, held high for whole op
vu_dst_addr  out  64  serializer destination address
vu_value  out  64  serializer input value
vu_field_type  out  5  serializer field_type
vu_done  in  1  serializer op complete (1-cycle pulse)
vu_bytes  in  4  bytes written by op, valid when vu_done=1
busy  out  1  message in progress
msg_done  out  1  1-cycle pulse, message complete
msg_len  out  32  total bytes written this message
err  out  1  sticky timeout error

Behaviour:
- Reset: all outputs 0 except fld_ready=1. FIFO empty, FSM IDLE, fin latch cleared. Reset mid-op abandons the op immediately; vu_en is 0 the next cycle.
- FIFO: push on fld_valid&fld_ready. fld_ready=0 when full, even if a pop occurs in the same cycle. Push and pop in the same non-full cycle are both honoured. Pushes are accepted in IDLE but entries are not popped until start.
- Tag value is {fld_num, 3'b000} zero-extended to 64 bits (wire type 0). vu_field_type=TAG_FTYPE. fld_type and fld_value are unused during the tag op.
- FSM states: IDLE, POP, TAG_RUN, TAG_GAP, VAL_RUN, VAL_GAP, DONE, ERR.
- IDLE:
  - On start: wptr←base_addr, msg_len←0, fin latch←0, busy←1, go POP.
  - err is cleared on start only.
- POP:
  - FIFO non-empty: dequeue into holding regs; drive vu_value, vu_field_type, vu_dst_addr=wptr; go TAG_RUN. vu_en rises the cycle after dequeue.
  - FIFO empty and fin latched: go DONE.
  - Otherwise wait.
- TAG_RUN / VAL_RUN:
  - vu_en=1 and inputs held stable.
  - On vu_done: wptr += vu_bytes, msg_len += vu_bytes (both zero-extended, wrap modulo width); go the matching GAP state.
  - A watchdog counter clears on entry; if it reaches TIMEOUT with no vu_done: err←1, vu_en←0, go ERR.
- TAG_GAP: vu_en=0 for exactly one cycle (the serializer clears its internal state on !en). Load value/fld_type, vu_dst_addr=updated wptr; go VAL_RUN.
- VAL_GAP: vu_en=0 for one cycle; go POP.
- DONE: msg_done=1 for one cycle; busy←0; go IDLE. msg_len holds until next start.
- ERR: busy=0, FIFO contents retained, wait for start (re-enters as in IDLE; FIFO not flushed).
- fin is latched whenever busy (or same cycle as start); fin never ends a message until the FIFO is empty and no op is in flight.
- vu_done outside a RUN state is ignored.
- Minimum per-field overhead: 1 POP + 2 GAP cycles plus the serializer latency of both ops.

Test Plan:
- Single field: start, base_addr=0x1000, fld_num=1, type=4, value=150, fin; model returns bytes 1 then 2 → vu_dst_addr 0x1000 then 0x1001, tag vu_value=0x08, msg_len=3, one msg_done pulse, busy=0 after.
- Three fields back-to-back (nums 1,2,300; values 1,0x7F,0x80) with model bytes 1/1, 1/1, 2/2 → addresses 0x0,0x1,0x2,0x3,0x4,0x6; msg_len=8; vu_en low ≥1 cycle between every op.
- Zigzag passthrough: fld_type=18, value=64'hFFFF_FFFF_FFFF_FFFF → tag op uses field_type 4; value op uses field_type 18 with value unchanged.
- Backpressure: push 4 entries before start → fld_ready=0, 5th push not accepted; after start the first pop re-asserts fld_ready next cycle; all 4 fields are issued in order.
- Timeout: model never returns vu_done → after 64 cycles err=1, vu_en=0, busy=0; a new start clears err and the next op issues.
- Reset during VAL_RUN → next cycle vu_en=0, busy=0, msg_len=0, fld_ready=1, no msg_done.

Source files
------------

// File: rtl/varint_field_seq.sv
// varint_field_seq: descriptor FIFO feeding the shared varint serializer as tag op then value op,
// tracking the destination pointer and message length from the serializer's byte counts.
module varint_field_seq #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 64,
  parameter logic [4:0] TAG_FTYPE  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic        fld_valid,
  output logic        fld_ready,
  input  logic [28:0] fld_num,
  input  logic [4:0]  fld_type,
  input  logic [63:0] fld_value,
  input  logic        fin,
  output logic        vu_en,
  output logic [63:0] vu_dst_addr,
  output logic [63:0] vu_value,
  output logic [4:0]  vu_field_type,
  input  logic        vu_done,
  input  logic [3:0]  vu_bytes,
  output logic        busy,
  output logic        msg_done,
  output logic [31:0] msg_len,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, POP, TAG_RUN, TAG_GAP, VAL_RUN, VAL_GAP, DONE, ERR} state_t;
  state_t        r_state, w_nxt;
  logic [97:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [63:0]   r_wptr, r_val, r_dst, r_vval;
  logic [4:0]    r_type, r_ft;
  logic [31:0]   r_len;
  logic [WW-1:0] r_wd;
  logic          r_fin, r_err;
  logic          w_full, w_empty, w_push, w_pop, w_run, w_idle, w_start, w_tmo;
  logic [97:0]   w_head;
  assign w_full        = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_empty       = r_wp == r_rp;
  assign w_push        = fld_valid && !w_full;
  assign w_pop         = r_state == POP && !w_empty;
  assign w_head        = r_mem[r_rp[AW-1:0]];
  assign w_run         = r_state == TAG_RUN || r_state == VAL_RUN;
  assign w_idle        = r_state == IDLE || r_state == ERR;
  assign w_start       = start && w_idle;
  assign w_tmo         = r_wd == WW'(TIMEOUT - 1);
  assign fld_ready     = !w_full;
  assign vu_en         = w_run;
  assign busy          = !w_idle;
  assign msg_done      = r_state == DONE;
  assign vu_dst_addr   = r_dst;
  assign vu_value      = r_vval;
  assign vu_field_type = r_ft;
  assign msg_len       = r_len;
  assign err           = r_err;
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE, ERR: w_nxt = start ? POP : r_state;
      POP:       w_nxt = !w_empty ? TAG_RUN : r_fin ? DONE : POP;
      TAG_RUN:   w_nxt = vu_done ? TAG_GAP : w_tmo ? ERR : TAG_RUN;
      TAG_GAP:   w_nxt = VAL_RUN;
      VAL_RUN:   w_nxt = vu_done ? VAL_GAP : w_tmo ? ERR : VAL_RUN;
      VAL_GAP:   w_nxt = POP;
      DONE:      w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {fld_num, fld_type, fld_value};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_wptr  <= '0;
      r_val   <= '0;
      r_type  <= '0;
      r_dst   <= '0;
      r_vval  <= '0;
      r_ft    <= '0;
      r_len   <= '0;
      r_wd    <= '0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wp    <= r_wp + (AW+1)'(w_push);
      r_rp    <= r_rp + (AW+1)'(w_pop);
      r_wd    <= (w_run && w_nxt == r_state) ? r_wd + WW'(1) : '0;
      r_fin   <= w_start ? fin : (busy && fin) ? 1'b1 : r_fin;
      if (w_start) begin
        r_wptr <= base_addr;
        r_len  <= '0;
        r_err  <= 1'b0;
      end
      if (w_run && vu_done) begin
        r_wptr <= r_wptr + 64'(vu_bytes);
        r_len  <= r_len + 32'(vu_bytes);
      end
      if (w_run && w_nxt == ERR) r_err <= 1'b1;
      if (w_pop) begin
        r_dst  <= r_wptr;
        r_vval <= {32'd0, w_head[97:69], 3'b000};
        r_ft   <= TAG_FTYPE;
        r_type <= w_head[68:64];
        r_val  <= w_head[63:0];
      end
      if (r_state == TAG_GAP) begin
        r_dst  <= r_wptr;
        r_vval <= r_val;
        r_ft   <= r_type;
      end
    end
  end
endmodule

// File: tb/tb_varint_field_seq.sv
// tb_varint_field_seq: scoreboard bench with a latency-configurable serializer responder.
module tb_varint_field_seq;
  typedef struct packed {logic [63:0] dst; logic [63:0] val; logic [4:0] ft;} op_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, fld_valid = 1'b0, fin = 1'b0, vu_done;
  logic [63:0] base_addr = '0, fld_value = '0;
  logic [28:0] fld_num = '0;
  logic [4:0]  fld_type = '0;
  logic [3:0]  vu_bytes;
  logic        fld_ready, vu_en, busy, msg_done, err;
  logic [63:0] vu_dst_addr, vu_value;
  logic [4:0]  vu_field_type;
  logic [31:0] msg_len;
  int          checks = 0, errors = 0, done_cnt = 0, lat = 2;
  bit          hang = 1'b0;
  op_t         sb[$];
  logic [3:0]  bq[$];
  logic [63:0] exp_wptr;

  varint_field_seq dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_num(fld_num),
    .fld_type(fld_type), .fld_value(fld_value), .fin(fin),
    .vu_en(vu_en), .vu_dst_addr(vu_dst_addr), .vu_value(vu_value),
    .vu_field_type(vu_field_type), .vu_done(vu_done), .vu_bytes(vu_bytes),
    .busy(busy), .msg_done(msg_done), .msg_len(msg_len), .err(err)
  );

  always #5 clk = ~clk;

  initial begin : serializer_model
    int cnt;
    cnt = 0;
    vu_done = 1'b0;
    vu_bytes = '0;
    forever begin
      @(posedge clk); #1;
      vu_done = 1'b0;
      vu_bytes = '0;
      cnt = vu_en ? cnt + 1 : 0;
      if (vu_en && !hang && cnt == lat) begin
        vu_done = 1'b1;
        vu_bytes = bq.size() > 0 ? bq.pop_front() : 4'd1;
      end
    end
  end

  initial begin : op_monitor
    op_t  cur, held;
    logic prev_en;
    prev_en = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (vu_en && !prev_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL op_unexpected dst=%h val=%h ft=%0d required no op", vu_dst_addr, vu_value, vu_field_type);
        end else begin
          cur = sb.pop_front();
          if (vu_dst_addr !== cur.dst || vu_value !== cur.val || vu_field_type !== cur.ft) begin
            errors++;
            $display("FAIL op_issue dst=%h val=%h ft=%0d required dst=%h val=%h ft=%0d",
                     vu_dst_addr, vu_value, vu_field_type, cur.dst, cur.val, cur.ft);
          end
        end
        held = '{vu_dst_addr, vu_value, vu_field_type};
      end else if (vu_en) begin
        checks++;
        if ({vu_dst_addr, vu_value, vu_field_type} !== held) begin
          errors++;
          $display("FAIL op_stable dst=%h val=%h ft=%0d required %h", vu_dst_addr, vu_value, vu_field_type, held);
        end
      end
      if (msg_done) done_cnt++;
      prev_en = vu_en;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic push_field(input logic [28:0] n, input logic [4:0] t, input logic [63:0] v,
                            input logic [3:0] tb, input logic [3:0] vb);
    int w;
    w = 0;
    while (!fld_ready && w < 100) begin cyc(1); w++; end
    checks++;
    if (fld_ready !== 1'b1) begin errors++; $display("FAIL push_ready got=%b required=1", fld_ready); end
    fld_valid = 1'b1; fld_num = n; fld_type = t; fld_value = v;
    cyc(1);
    fld_valid = 1'b0;
    sb.push_back('{exp_wptr, {32'd0, n, 3'b000}, 5'd4});
    exp_wptr += 64'(tb);
    sb.push_back('{exp_wptr, v, t});
    exp_wptr += 64'(vb);
    bq.push_back(tb);
    bq.push_back(vb);
  endtask

  task automatic do_start(input logic [63:0] b, input logic f);
    start = 1'b1; base_addr = b; fin = f;
    cyc(1);
    start = 1'b0; fin = 1'b0;
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt != n0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fld_ready, vu_en, busy, msg_done, err} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got=%b required=10000", {fld_ready, vu_en, busy, msg_done, err});
    end
    checks++;
    if ({vu_dst_addr, vu_value, vu_field_type, msg_len} !== '0) begin
      errors++; $display("FAIL reset_data dst=%h val=%h ft=%0d len=%0d required all 0", vu_dst_addr, vu_value, vu_field_type, msg_len);
    end
  endtask

  task automatic test_single();
    int n0; bit ok;
    exp_wptr = 64'h1000;
    push_field(29'd1, 5'd4, 64'd150, 4'd1, 4'd2);
    n0 = done_cnt;
    do_start(64'h1000, 1'b1);
    wait_done(n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done got=timeout required=msg_done"); end
    checks++;
    if (msg_len !== 32'd3 || busy !== 1'b0) begin errors++; $display("FAIL single_len len=%0d busy=%b required len=3 busy=0", msg_len, busy); end
    cyc(4);
    checks++;
    if (done_cnt !== n0 + 1 || sb.size() != 0) begin
      errors++; $display("FAIL single_pulses done=%0d pending=%0d required done=%0d pending=0", done_cnt - n0, sb.size(), 1);
    end
  endtask

  task automatic test_back_to_back();
    int n0; bit ok;
    exp_wptr = 64'h0;
    n0 = done_cnt;
    do_start(64'h0, 1'b0);
    push_field(29'd1, 5'd0, 64'd1, 4'd1, 4'd1);
    push_field(29'd2, 5'd0, 64'h7F, 4'd1, 4'd1);
    push_field(29'd300, 5'd0, 64'h80, 4'd2, 4'd2);
    fin = 1'b1;
    cyc(1);
    fin = 1'b0;
    wait_done(n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done got=timeout required=msg_done"); end
    checks++;
    if (msg_len !== 32'd8) begin errors++; $display("FAIL b2b_len got=%0d required=8", msg_len); end
    cyc(3);
    checks++;
    if (sb.size() != 0 || done_cnt !== n0 + 1) begin
      errors++; $display("FAIL b2b_ops pending=%0d done=%0d required pending=0 done=1", sb.size(), done_cnt - n0);
    end
  endtask

  task automatic test_zigzag();
    int n0; bit ok;
    exp_wptr = 64'h2000;
    push_field(29'd9, 5'd18, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 4'd10);
    n0 = done_cnt;
    do_start(64'h2000, 1'b1);
    wait_done(n0, ok);
    checks++;
    if (!ok || msg_len !== 32'd11) begin errors++; $display("FAIL zigzag_len got=%0d ok=%b required=11", msg_len, ok); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL zigzag_ops pending=%0d required=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int n0; bit ok;
    exp_wptr = 64'h200;
    for (int i = 0; i < 4; i++) push_field(29'(10 + i), 5'(i), 64'(100 + i), 4'd1, 4'd1);
    checks++;
    if (fld_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b required=0", fld_ready); end
    fld_valid = 1'b1; fld_num = 29'd99; fld_type = 5'd9; fld_value = 64'd999;
    cyc(1);
    fld_valid = 1'b0;
    n0 = done_cnt;
    do_start(64'h200, 1'b1);
    checks++;
    if (fld_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_wait got=%b required=0", fld_ready); end
    cyc(1);
    checks++;
    if (fld_ready !== 1'b1) begin errors++; $display("FAIL bp_reassert got=%b required=1", fld_ready); end
    wait_done(n0, ok);
    checks++;
    if (!ok || msg_len !== 32'd8 || sb.size() != 0) begin
      errors++; $display("FAIL bp_done len=%0d pending=%0d ok=%b required len=8 pending=0", msg_len, sb.size(), ok);
    end
  endtask

  task automatic test_timeout();
    int w, hi, n0; bit ok;
    hang = 1'b1;
    exp_wptr = 64'h3000;
    push_field(29'd3, 5'd0, 64'd5, 4'd1, 4'd1);
    void'(sb.pop_back());
    bq.delete();
    do_start(64'h3000, 1'b0);
    w = 0;
    while (!vu_en && w < 50) begin cyc(1); w++; end
    hi = 0;
    while (vu_en && hi < 200) begin hi++; cyc(1); end
    checks++;
    if (hi != 64) begin errors++; $display("FAIL tmo_cycles got=%0d required=64", hi); end
    checks++;
    if ({err, vu_en, busy} !== 3'b100) begin errors++; $display("FAIL tmo_state err/en/busy=%b required=100", {err, vu_en, busy}); end
    hang = 1'b0;
    exp_wptr = 64'h4000;
    push_field(29'd5, 5'd0, 64'd3, 4'd1, 4'd1);
    n0 = done_cnt;
    do_start(64'h4000, 1'b1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_restart err=%b busy=%b required err=0 busy=1", err, busy); end
    wait_done(n0, ok);
    checks++;
    if (!ok || msg_len !== 32'd2 || sb.size() != 0) begin
      errors++; $display("FAIL tmo_recover len=%0d pending=%0d ok=%b required len=2 pending=0", msg_len, sb.size(), ok);
    end
  endtask

  task automatic test_reset_mid_op();
    int w, n0;
    lat = 20;
    exp_wptr = 64'h5000;
    push_field(29'd7, 5'd7, 64'd9, 4'd1, 4'd1);
    do_start(64'h5000, 1'b1);
    w = 0;
    while (!(vu_en && vu_field_type == 5'd7) && w < 300) begin cyc(1); w++; end
    checks++;
    if (!(vu_en && vu_field_type == 5'd7)) begin errors++; $display("FAIL rst_reach_val en=%b ft=%0d required en=1 ft=7", vu_en, vu_field_type); end
    cyc(3);
    n0 = done_cnt;
    reset = 1'b1;
    cyc(1);
    checks++;
    if ({vu_en, busy, fld_ready, msg_done} !== 4'b0010 || msg_len !== 32'd0) begin
      errors++; $display("FAIL rst_mid en/busy/rdy/done=%b len=%0d required 0010 len=0", {vu_en, busy, fld_ready, msg_done}, msg_len);
    end
    reset = 1'b0;
    cyc(5);
    checks++;
    if (done_cnt != n0 || sb.size() != 0) begin
      errors++; $display("FAIL rst_no_done done=%0d pending=%0d required 0 0", done_cnt - n0, sb.size());
    end
    bq.delete();
    lat = 2;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zigzag();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
